mem_requester: RTL
==================

MEM_REQUESTER -- requirements
Module: mem_requester

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 64, maximum cycles spent waiting on either MFC edge before the transfer aborts (range 2..255).
REQ-002 Port: Clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: Reset  input  1  synchronous, active-low reset (sampled on rising Clk).
REQ-004 Port: Start  input  1  CPU request strobe; sampled only in IDLE.
REQ-005 Port: CpuRW  input  1  1 = load/read, 0 = store/write.
REQ-006 Port: CpuWordByte  input  1  1 = 32-bit word, 0 = byte.
REQ-007 Port: CpuAddr  input  8  byte address.
REQ-008 Port: CpuWData  input  32  store data; byte stores use [7:0].
REQ-009 Port: CpuRData  output  32  load result, held until next load completes.
REQ-010 Port: Busy  output  1  high from the cycle after Start is accepted until Done.
REQ-011 Port: Done  output  1  one-cycle completion pulse.
REQ-012 Port: Error  output  1  one-cycle pulse, coincident with Done, on timeout abort.
REQ-013 Port: MFA  output  1  memory function active, to memory.
REQ-014 Port: MFC  input  1  memory function complete, asynchronous to Clk.
REQ-015 Port: ReadWrite  output  1  registered copy of CpuRW.
REQ-016 Port: wordByte  output  1  registered copy of CpuWordByte.
REQ-017 Port: Address  output  8  registered copy of CpuAddr.
REQ-018 Port: Data  inout  32  shared data bus; driven only during stores, else high-Z.

Function
REQ-019 MFC passes through a 2-flop synchronizer (MFC_s); the FSM uses MFC_s only.
REQ-020 States: IDLE, REQ, REL, FIN.
REQ-021 IDLE: Start=1 -> latch CpuRW/CpuWordByte/CpuAddr/CpuWData into ReadWrite/wordByte/Address/write register, MFA<=1, go to REQ; Start=0 -> stay.
REQ-022 Start in any state other than IDLE is ignored; no queuing.
REQ-023 Address, ReadWrite, wordByte held stable from REQ entry through FIN.
REQ-024 Store: Data driven with write register from REQ entry until leaving REL; word = full 32 bits, byte = {24'b0, CpuWData[7:0]}.
REQ-025 Load: Data never driven; on the first cycle MFC_s=1 in REQ, capture Data -> CpuRData (word = Data[31:0], byte = {24'b0, Data[7:0]}).
REQ-026 REQ: MFC_s=1 -> MFA<=0, go to REL.
REQ-027 REL: MFC_s=0 -> go to FIN; store data released (high-Z) on this transition.
REQ-028 FIN: Done=1 for one cycle, Busy<=0, go to IDLE.
REQ-029 Minimum Start-to-Done latency = 6 cycles with zero-delay memory (2 sync cycles per MFC edge + REQ + FIN).
REQ-030 MFC_s=1 while in IDLE is ignored; a new request is not issued until MFC_s=0 (IDLE holds with Busy=1 until then).

Reset
REQ-031 Reset=0 at a rising Clk: state IDLE, MFA=0, Done=0, Error=0, Busy=0, Data high-Z, CpuRData=0, Address=0, ReadWrite=1, wordByte=1, synchronizer and timeout counter cleared.
REQ-032 Reset mid-transfer aborts with no Done pulse; MFA drops in the same cycle reset is sampled.

Configuration
REQ-033 Macro MEM_REQ_TIMEOUT_EN: when defined, an 8-bit counter clears on entry to REQ and REL, increments each cycle spent there, and on reaching TIMEOUT_CYCLES forces MFA=0, Data high-Z, CpuRData unchanged, and goes to FIN with Error=1 and Done=1.
REQ-034 Without MEM_REQ_TIMEOUT_EN: no counter, Error tied 0, FSM waits indefinitely on MFC.

Verification
REQ-035 Word store: CpuAddr=8'h10, CpuWData=32'hDEADBEEF, responder raises MFC 3 cycles after MFA -> Data=32'hDEADBEEF while MFA high, mem bytes 10..13 = DE AD BE EF, one Done pulse, Error=0.
REQ-036 Word load of addr 8'h10 after REQ-035 -> CpuRData=32'hDEADBEEF at Done; Data never driven by block.
REQ-037 Byte store 8'hA5 to addr 8'h20 then byte load -> CpuRData=32'h000000A5.
REQ-038 Start pulsed again during REQ -> ignored; exactly one MFA pulse and one Done.
REQ-039 With MEM_REQ_TIMEOUT_EN, TIMEOUT_CYCLES=8, MFC held 0 -> MFA falls 8 cycles after REQ entry, Done=Error=1 for one cycle, Data high-Z.
REQ-040 Reset=0 asserted in REL during a store -> next cycle MFA=0, Data high-Z, Busy=0, no Done.

Source files
------------

// File: rtl/mem_requester.sv
// -----------------------------------------------------------------------------
// mem_requester
//
// Purpose:
//   Bridges a simple CPU load/store strobe to an asynchronous MFA/MFC memory
//   handshake. A request latches the CPU address/control/data, raises MFA,
//   waits for the synchronised MFC to rise (capturing load data), drops MFA,
//   waits for MFC to fall, then pulses Done for one cycle.
//
// Optional feature:
//   MEM_REQ_TIMEOUT_EN - when defined, an 8-bit watchdog counts cycles spent
//   waiting on each MFC edge; on reaching TIMEOUT_CYCLES the transfer aborts
//   with Done and Error pulsed together. When undefined, the FSM waits
//   indefinitely and Error is tied low.
//
// Parameters:
//   TIMEOUT_CYCLES  cycles allowed per MFC edge before abort (2..255)
//
// Ports:
//   Clk          in   clock, all state on rising edge
//   Reset        in   synchronous active-low reset
//   Start        in   request strobe, only looked at while idle
//   CpuRW        in   1 = load, 0 = store
//   CpuWordByte  in   1 = 32-bit word, 0 = byte
//   CpuAddr      in   [7:0] byte address
//   CpuWData     in   [31:0] store data (byte stores use [7:0])
//   CpuRData     out  [31:0] last load result
//   Busy         out  transfer in progress
//   Done         out  one-cycle completion pulse
//   Error        out  one-cycle abort pulse, coincident with Done
//   MFA          out  memory function active
//   MFC          in   memory function complete (asynchronous)
//   ReadWrite    out  latched CpuRW
//   wordByte     out  latched CpuWordByte
//   Address      out  [7:0] latched CpuAddr
//   Data         io   [31:0] shared data bus, driven only during stores
// -----------------------------------------------------------------------------
module mem_requester #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic        CpuRW,
  input  logic        CpuWordByte,
  input  logic [7:0]  CpuAddr,
  input  logic [31:0] CpuWData,
  output logic [31:0] CpuRData,
  output logic        Busy,
  output logic        Done,
  output logic        Error,
  output logic        MFA,
  input  logic        MFC,
  output logic        ReadWrite,
  output logic        wordByte,
  output logic [7:0]  Address,
  inout  wire  [31:0] Data
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_REL,
    ST_FIN
  } state_t;

  state_t      r_state;
  logic        r_mfcMeta;
  logic        r_mfcSync;
  logic        r_pending;
  logic        r_drive;
  logic [31:0] r_wdata;

  // Reject out-of-range configurations at elaboration time.
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_badTimeout
    $error("mem_requester: TIMEOUT_CYCLES must be within 2..255");
  end

  // The bus is only ours while a store is between REQ entry and REL exit.
  assign Data = r_drive ? r_wdata : 32'bz;

`ifdef MEM_REQ_TIMEOUT_EN
  logic [7:0] r_count;
  logic       w_timeout;

  assign w_timeout = (r_count == 8'(TIMEOUT_CYCLES - 1));

  // Watchdog: held at zero outside the wait states and on the REQ->REL
  // handoff, so each MFC edge gets its own full budget.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_count <= 8'd0;
    end else if (r_state == ST_IDLE || r_state == ST_FIN ||
                 (r_state == ST_REQ && r_mfcSync)) begin
      r_count <= 8'd0;
    end else begin
      r_count <= r_count + 8'd1;
    end
  end
`else
  assign Error = 1'b0;
`endif

  // Main handshake FSM with registered outputs. MFC is only ever used
  // through the two-flop synchroniser.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state   <= ST_IDLE;
      r_mfcMeta <= 1'b0;
      r_mfcSync <= 1'b0;
      r_pending <= 1'b0;
      r_drive   <= 1'b0;
      r_wdata   <= 32'd0;
      CpuRData  <= 32'd0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      MFA       <= 1'b0;
      ReadWrite <= 1'b1;
      wordByte  <= 1'b1;
      Address   <= 8'd0;
`ifdef MEM_REQ_TIMEOUT_EN
      Error     <= 1'b0;
`endif
    end else begin
      r_mfcMeta <= MFC;
      r_mfcSync <= r_mfcMeta;
      Done      <= 1'b0;
`ifdef MEM_REQ_TIMEOUT_EN
      Error     <= 1'b0;
`endif

      case (r_state)
        ST_IDLE: begin
          if (r_pending) begin
            // Accepted earlier while memory still showed MFC; issue now.
            if (!r_mfcSync) begin
              r_pending <= 1'b0;
              MFA       <= 1'b1;
              r_drive   <= !ReadWrite;
              r_state   <= ST_REQ;
            end
          end else if (Start) begin
            ReadWrite <= CpuRW;
            wordByte  <= CpuWordByte;
            Address   <= CpuAddr;
            r_wdata   <= CpuWordByte ? CpuWData : {24'd0, CpuWData[7:0]};
            Busy      <= 1'b1;
            if (!r_mfcSync) begin
              MFA     <= 1'b1;
              r_drive <= !CpuRW;
              r_state <= ST_REQ;
            end else begin
              r_pending <= 1'b1;
            end
          end
        end

        ST_REQ: begin
          // Completion wins over a coincident watchdog expiry.
          if (r_mfcSync) begin
            MFA <= 1'b0;
            if (ReadWrite) begin
              CpuRData <= wordByte ? Data : {24'd0, Data[7:0]};
            end
            r_state <= ST_REL;
          end
`ifdef MEM_REQ_TIMEOUT_EN
          else if (w_timeout) begin
            MFA     <= 1'b0;
            r_drive <= 1'b0;
            Done    <= 1'b1;
            Error   <= 1'b1;
            r_state <= ST_FIN;
          end
`endif
        end

        ST_REL: begin
          if (!r_mfcSync) begin
            r_drive <= 1'b0;
            Done    <= 1'b1;
            r_state <= ST_FIN;
          end
`ifdef MEM_REQ_TIMEOUT_EN
          else if (w_timeout) begin
            r_drive <= 1'b0;
            Done    <= 1'b1;
            Error   <= 1'b1;
            r_state <= ST_FIN;
          end
`endif
        end

        ST_FIN: begin
          // Done is already high for this cycle; Busy falls with it.
          Busy    <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
